// File: rtl/sram_ctrl_param_if.sv
// Request/response bundle for sram_ctrl_param; rd_cnt/wr_cnt exist only
// when SRAM_CTRL_STATS_EN is defined.
interface sram_ctrl_param_if #(
   parameter int DATA_W = 9,
   parameter int ADDR_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              init_busy;
`ifdef SRAM_CTRL_STATS_EN
   logic [15:0]       rd_cnt;
   logic [15:0]       wr_cnt;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy, rd_cnt, wr_cnt
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy, rd_cnt, wr_cnt
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );
`endif
endinterface

// File: rtl/sram_ctrl_param.sv
// Parametrised single-port SRAM: zero-init sequencer, range check and an RD_LAT
// (1 or 2) read pipeline. Defining SRAM_CTRL_STATS_EN adds saturating rd/wr counters.
module sram_ctrl_param #(
   parameter int DATA_W = 9,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
) (
   input logic              clk,
   input logic              rst,
   sram_ctrl_param_if.slave bus
);
   typedef enum logic {INIT, RUN} state_e;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              rspValid1_q, rspValid1_d;
   logic [DATA_W-1:0] rspRdata1_q, rspRdata1_d;
   logic              rspErr1_q, rspErr1_d;
   logic              accept;
   logic              inRange;

   assign bus.req_ready = (state_q == RUN);
   assign bus.init_busy = (state_q == INIT);
   assign accept        = bus.req_valid && (state_q == RUN);
   assign inRange       = ({1'b0, bus.req_addr} < DEPTH_C);

   // INIT walks cnt over every word once, then hands over to RUN for good
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + CNT_ONE;
         if (cnt_q == LAST_IDX) begin
            state_d = RUN;
         end
      end
   end

   always_comb begin
      rspValid1_d = 1'b0;
      rspRdata1_d = '0;
      rspErr1_d   = 1'b0;
      if (accept && !bus.req_we) begin
         rspValid1_d = 1'b1;
         rspErr1_d   = !inRange;
         if (inRange) begin
            rspRdata1_d = mem_q[bus.req_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         rspValid1_q <= 1'b0;
         rspRdata1_q <= '0;
         rspErr1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rspValid1_q <= rspValid1_d;
         rspRdata1_q <= rspRdata1_d;
         rspErr1_q   <= rspErr1_d;
      end
   end

   // Storage is not reset; the INIT sweep is what clears it
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= '0;
         end else if (accept && bus.req_we && inRange) begin
            mem_q[bus.req_addr] <= bus.req_wdata;
         end
      end
   end

   if (RD_LAT == 2) begin : gLat2
      logic              rspValid2_q;
      logic [DATA_W-1:0] rspRdata2_q;
      logic              rspErr2_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rspValid2_q <= 1'b0;
            rspRdata2_q <= '0;
            rspErr2_q   <= 1'b0;
         end else begin
            rspValid2_q <= rspValid1_q;
            rspRdata2_q <= rspRdata1_q;
            rspErr2_q   <= rspErr1_q;
         end
      end

      assign bus.rsp_valid = rspValid2_q;
      assign bus.rsp_rdata = rspRdata2_q;
      assign bus.rsp_err   = rspErr2_q;
   end else begin : gLat1
      assign bus.rsp_valid = rspValid1_q;
      assign bus.rsp_rdata = rspRdata1_q;
      assign bus.rsp_err   = rspErr1_q;
   end

`ifdef SRAM_CTRL_STATS_EN
   logic [15:0] rdCnt_q, rdCnt_d;
   logic [15:0] wrCnt_q, wrCnt_d;

   // accept is never high in INIT, so the counters hold there naturally
   always_comb begin
      rdCnt_d = rdCnt_q;
      wrCnt_d = wrCnt_q;
      if (accept && !bus.req_we && (rdCnt_q != 16'hFFFF)) begin
         rdCnt_d = rdCnt_q + 16'd1;
      end
      if (accept && bus.req_we && (wrCnt_q != 16'hFFFF)) begin
         wrCnt_d = wrCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdCnt_q <= '0;
         wrCnt_q <= '0;
      end else begin
         rdCnt_q <= rdCnt_d;
         wrCnt_q <= wrCnt_d;
      end
   end

   assign bus.rd_cnt = rdCnt_q;
   assign bus.wr_cnt = wrCnt_q;
`endif
endmodule
